// File: rtl/alu_share_arb_pkg.sv
// Shared definitions for the two-requester ALU sharing arbiter: default widths,
// per-requester slot states and the ALUCtl encoding seen by alu_v2.
package alu_share_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTL_W  = 7;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_HELD     = 2'd2
    } slot_state_t;

    localparam logic [DEF_CTL_W-1:0] ALU_AND  = 7'h00;
    localparam logic [DEF_CTL_W-1:0] ALU_OR   = 7'h01;
    localparam logic [DEF_CTL_W-1:0] ALU_ADD  = 7'h02;
    localparam logic [DEF_CTL_W-1:0] ALU_XOR  = 7'h03;
    localparam logic [DEF_CTL_W-1:0] ALU_SUB  = 7'h06;
    localparam logic [DEF_CTL_W-1:0] ALU_SLT  = 7'h07;
    localparam logic [DEF_CTL_W-1:0] ALU_SLTU = 7'h08;

endpackage

// File: rtl/alu_share_arb_if.sv
// One requester's request/response channel to the ALU sharing arbiter.
interface alu_share_arb_if
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTL_W  = DEF_CTL_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic [CTL_W-1:0]  req_ctl;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_br;

    modport master (
        output req_valid, req_ctl, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_br
    );

    modport slave (
        input  req_valid, req_ctl, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_br
    );

endinterface

// File: rtl/alu_share_arb_slot.sv
// Per-requester slot: tracks one outstanding op and buffers its result until drained.
//   state       | meaning
//   ST_FREE     | no op outstanding, may be granted
//   ST_INFLIGHT | operands sit in the ALU input stage, result captured next edge
//   ST_HELD     | result buffered, rsp_valid high until rsp_ready
module alu_share_slot
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_accept,
    input  logic              i_capture,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_br,
    input  logic              i_rsp_ready,
    output logic              o_free,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_out,
    output logic              o_rsp_br
);

    slot_state_t r_state;
    slot_state_t w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FREE:     if (i_accept) w_state_nxt = ST_INFLIGHT;
            ST_INFLIGHT: w_state_nxt = ST_HELD;
            ST_HELD:     if (i_rsp_ready) w_state_nxt = ST_FREE;
            default:     w_state_nxt = ST_FREE;
        endcase
    end

    always_comb begin
        o_free      = 1'b0;
        o_rsp_valid = 1'b0;
        unique case (r_state)
            ST_FREE:     o_free = 1'b1;
            ST_INFLIGHT: ;
            ST_HELD:     o_rsp_valid = 1'b1;
            default:     ;
        endcase
    end

    // Capture is only ever pulsed on the INFLIGHT->HELD edge, so HELD data stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rsp_out <= '0;
            o_rsp_br  <= 1'b0;
        end else if (i_capture) begin
            o_rsp_out <= i_alu_out;
            o_rsp_br  <= i_alu_br;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin share of one external combinational ALU between two requesters:
// registers the winner's operands into the ALU input stage and routes the result back.
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTL_W  = DEF_CTL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arb_if.slave    if_req0,
    alu_share_arb_if.slave    if_req1,
    output logic [CTL_W-1:0]  o_alu_ctl,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_br
);

    logic              w_free0, w_free1;
    logic              w_elig0, w_elig1;
    logic              w_grant0, w_grant1;
    logic              w_cap0, w_cap1;
    logic              w_rsp_valid0, w_rsp_valid1;
    logic [DATA_W-1:0] w_rsp_out0, w_rsp_out1;
    logic              w_rsp_br0, w_rsp_br1;

    logic              r_s1_valid;
    logic              r_s1_id;
    logic              r_last_grant;
    logic [CTL_W-1:0]  r_alu_ctl;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;

    assign w_elig0 = if_req0.req_valid & w_free0;
    assign w_elig1 = if_req1.req_valid & w_free1;

    // On a tie the requester that did not win last time goes first.
    assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
    assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

    assign if_req0.req_ready = w_free0 & w_grant0;
    assign if_req1.req_ready = w_free1 & w_grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_id      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_ctl    <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
        end else begin
            r_s1_valid <= w_grant0 | w_grant1;
            if (w_grant0) begin
                r_s1_id      <= 1'b0;
                r_last_grant <= 1'b0;
                r_alu_ctl    <= if_req0.req_ctl;
                r_alu_a      <= if_req0.req_a;
                r_alu_b      <= if_req0.req_b;
            end else if (w_grant1) begin
                r_s1_id      <= 1'b1;
                r_last_grant <= 1'b1;
                r_alu_ctl    <= if_req1.req_ctl;
                r_alu_a      <= if_req1.req_a;
                r_alu_b      <= if_req1.req_b;
            end
        end
    end

    assign o_alu_ctl = r_alu_ctl;
    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;

    assign w_cap0 = r_s1_valid & ~r_s1_id;
    assign w_cap1 = r_s1_valid & r_s1_id;

    alu_share_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_accept    (w_grant0),
        .i_capture   (w_cap0),
        .i_alu_out   (i_alu_out),
        .i_alu_br    (i_alu_br),
        .i_rsp_ready (if_req0.rsp_ready),
        .o_free      (w_free0),
        .o_rsp_valid (w_rsp_valid0),
        .o_rsp_out   (w_rsp_out0),
        .o_rsp_br    (w_rsp_br0)
    );

    alu_share_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_accept    (w_grant1),
        .i_capture   (w_cap1),
        .i_alu_out   (i_alu_out),
        .i_alu_br    (i_alu_br),
        .i_rsp_ready (if_req1.rsp_ready),
        .o_free      (w_free1),
        .o_rsp_valid (w_rsp_valid1),
        .o_rsp_out   (w_rsp_out1),
        .o_rsp_br    (w_rsp_br1)
    );

    assign if_req0.rsp_valid = w_rsp_valid0;
    assign if_req0.rsp_out   = w_rsp_out0;
    assign if_req0.rsp_br    = w_rsp_br0;
    assign if_req1.rsp_valid = w_rsp_valid1;
    assign if_req1.rsp_out   = w_rsp_out1;
    assign if_req1.rsp_br    = w_rsp_br1;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table, hand sequences for the
// multi-cycle corners, and a per-requester scoreboard fed by a small ALU model.
`timescale 1ns/1ps
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int CW = DEF_CTL_W;
    localparam int NV = 8;

    typedef struct {
        bit            id;
        logic [CW-1:0] ctl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_out;
        logic          exp_br;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_share_arb_if if0 ();
    alu_share_arb_if if1 ();

    logic [CW-1:0] alu_ctl;
    logic [DW-1:0] alu_a, alu_b, alu_out;
    logic          alu_br;

    alu_share_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req0   (if0),
        .if_req1   (if1),
        .o_alu_ctl (alu_ctl),
        .o_alu_a   (alu_a),
        .o_alu_b   (alu_b),
        .i_alu_out (alu_out),
        .i_alu_br  (alu_br)
    );

    int n_pass = 0;
    int n_total = 0;
    int cnt_rsp0 = 0;
    int cnt_rsp1 = 0;
    logic [DW:0] q0[$];
    logic [DW:0] q1[$];

    function automatic logic [DW:0] alu_ref(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
        logic [DW-1:0] o;
        logic          br;
        o  = '0;
        br = 1'b0;
        case (c)
            ALU_AND:  o = a & b;
            ALU_OR:   o = a | b;
            ALU_XOR:  o = a ^ b;
            ALU_ADD:  o = a + b;
            ALU_SUB:  o = a - b;
            ALU_SLT:  begin br = ($signed(a) < $signed(b)); o = {{(DW-1){1'b0}}, br}; end
            ALU_SLTU: begin br = (a < b); o = {{(DW-1){1'b0}}, br}; end
            default:  ;
        endcase
        return {br, o};
    endfunction

    always_comb {alu_br, alu_out} = alu_ref(alu_ctl, alu_a, alu_b);

    task automatic check(input bit ok, input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        check(act === exp, nm, act, exp);
    endtask

    // Scoreboard: accepted requests push a model result, drained responses pop and compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (if0.req_valid && if0.req_ready) q0.push_back(alu_ref(if0.req_ctl, if0.req_a, if0.req_b));
            if (if1.req_valid && if1.req_ready) q1.push_back(alu_ref(if1.req_ctl, if1.req_a, if1.req_b));
            if (if0.rsp_valid && if0.rsp_ready) begin
                cnt_rsp0++;
                if (q0.size() == 0) check_eq("sb0_unexpected_rsp", 64'(q0.size()), 64'd1);
                else check_eq("sb0_rsp", {if0.rsp_br, if0.rsp_out}, q0.pop_front());
            end
            if (if1.rsp_valid && if1.rsp_ready) begin
                cnt_rsp1++;
                if (q1.size() == 0) check_eq("sb1_unexpected_rsp", 64'(q1.size()), 64'd1);
                else check_eq("sb1_rsp", {if1.rsp_br, if1.rsp_out}, q1.pop_front());
            end
        end
    end

    task automatic drv_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit id, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (id) begin
            if1.req_valid = v; if1.req_ctl = c; if1.req_a = a; if1.req_b = b;
        end else begin
            if0.req_valid = v; if0.req_ctl = c; if0.req_a = a; if0.req_b = b;
        end
    endtask

    // {valid, br, out}
    function automatic logic [DW+1:0] rsp_of(input bit id);
        return id ? {if1.rsp_valid, if1.rsp_br, if1.rsp_out} : {if0.rsp_valid, if0.rsp_br, if0.rsp_out};
    endfunction

    function automatic logic rdy_of(input bit id);
        return id ? if1.req_ready : if0.req_ready;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t          vecs [NV];
    logic [CW-1:0] codes [5];
    logic [DW+1:0] oth, r;
    int            prev_g, g0, g1, before1, before0;
    bit            alt_ok, seen, no_pulse;

    initial begin
        vecs[0] = '{1'b0, ALU_AND,  32'h0000_000F, 32'h0000_0055, 32'h0000_0005, 1'b0};
        vecs[1] = '{1'b1, ALU_SLT,  32'h0000_0000, 32'h0000_0002, 32'h0000_0001, 1'b1};
        vecs[2] = '{1'b0, ALU_OR,   32'h0000_000F, 32'h0000_0055, 32'h0000_005F, 1'b0};
        vecs[3] = '{1'b1, ALU_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0};
        vecs[4] = '{1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
        vecs[5] = '{1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[6] = '{1'b0, ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[7] = '{1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
        codes = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};

        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        if0.rsp_ready = 1'b1;
        if1.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_rsp0", rsp_of(0), '0);
        check_eq("rst_rsp1", rsp_of(1), '0);
        check_eq("rst_alu", {alu_ctl, alu_a, alu_b}, '0);
        rst_n = 1'b1;

        // Collision right after reset: requester 0 wins the first tie
        drv_pt();
        set_req(0, 1'b1, ALU_ADD, 32'd10000, 32'd111);
        set_req(1, 1'b1, ALU_SUB, 32'd10000, 32'd111);
        @(negedge clk);
        check_eq("col_rdy", {if0.req_ready, if1.req_ready}, 2'b10);
        drv_pt();
        if0.req_valid = 1'b0;
        @(negedge clk);
        check_eq("col_rdy1_next", if1.req_ready, 1'b1);
        check_eq("col_rsp0_lat", if0.rsp_valid, 1'b0);
        drv_pt();
        if1.req_valid = 1'b0;
        @(negedge clk);
        check_eq("col_rsp0", rsp_of(0), {1'b1, 1'b0, 32'd10111});
        check_eq("col_rsp1_lat", if1.rsp_valid, 1'b0);
        @(negedge clk);
        check_eq("col_rsp1", rsp_of(1), {1'b1, 1'b0, 32'd9889});
        check_eq("col_rsp0_drained", if0.rsp_valid, 1'b0);
        @(negedge clk);
        check_eq("col_rsp1_drained", if1.rsp_valid, 1'b0);

        // Vector table: single ops, 2-edge latency, other requester untouched
        for (int i = 0; i < NV; i++) begin
            oth = rsp_of(!vecs[i].id);
            drv_pt();
            set_req(vecs[i].id, 1'b1, vecs[i].ctl, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check_eq($sformatf("tbl%0d_rdy", i), rdy_of(vecs[i].id), 1'b1);
            drv_pt();
            set_req(vecs[i].id, 1'b0, '0, '0, '0);
            @(negedge clk);
            check_eq($sformatf("tbl%0d_early", i), rsp_of(vecs[i].id) >> (DW + 1), 1'b0);
            @(negedge clk);
            r = rsp_of(vecs[i].id);
            check_eq($sformatf("tbl%0d_rsp", i), r, {1'b1, vecs[i].exp_br, vecs[i].exp_out});
            check_eq($sformatf("tbl%0d_other", i), rsp_of(!vecs[i].id), oth);
            @(negedge clk);
            check_eq($sformatf("tbl%0d_drain", i), rsp_of(vecs[i].id) >> (DW + 1), 1'b0);
        end

        // Backpressure on requester 0 while requester 1 keeps completing
        drv_pt();
        if0.rsp_ready = 1'b0;
        set_req(0, 1'b1, ALU_OR, 32'h0F, 32'h55);
        @(negedge clk);
        check_eq("bp_rdy0", if0.req_ready, 1'b1);
        drv_pt();
        set_req(0, 1'b1, ALU_ADD, 32'd7, 32'd8);
        set_req(1, 1'b1, ALU_ADD, 32'd100, 32'd5);
        @(negedge clk);
        check_eq("bp_inflight_rdy0", if0.req_ready, 1'b0);
        before1 = cnt_rsp1;
        before0 = cnt_rsp0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold%0d", k), {if0.req_ready, rsp_of(0)}, {1'b0, 1'b1, 1'b0, 32'h5F});
        end
        check(cnt_rsp1 - before1 >= 1, "bp_req1_progress", 64'(cnt_rsp1 - before1), 64'd1);
        drv_pt();
        if0.rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_drain_no_accept", {if0.req_ready, if0.rsp_valid}, 2'b01);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = if0.req_ready;
        end
        check_eq("bp_second_accept", seen, 1'b1);
        drv_pt();
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);
        check_eq("bp_rsp0_count", 64'(cnt_rsp0 - before0), 64'd2);

        // Fairness: both valid continuously, grants must alternate
        drv_pt();
        set_req(0, 1'b1, codes[$urandom_range(0, 4)], $urandom, $urandom);
        set_req(1, 1'b1, codes[$urandom_range(0, 4)], $urandom, $urandom);
        prev_g = -1; g0 = 0; g1 = 0; alt_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq($sformatf("fair%0d_one_ready", c), if0.req_ready & if1.req_ready, 1'b0);
            if (if0.req_ready) begin
                if (prev_g == 0) alt_ok = 1'b0;
                prev_g = 0; g0++;
            end
            if (if1.req_ready) begin
                if (prev_g == 1) alt_ok = 1'b0;
                prev_g = 1; g1++;
            end
            seen = if0.req_ready;
            r[0] = if1.req_ready;
            drv_pt();
            if (seen) set_req(0, 1'b1, codes[$urandom_range(0, 4)], $urandom, $urandom);
            if (r[0]) set_req(1, 1'b1, codes[$urandom_range(0, 4)], $urandom, $urandom);
        end
        check_eq("fair_alternate", alt_ok, 1'b1);
        check(g0 >= 6, "fair_g0", 64'(g0), 64'd6);
        check(g1 >= 6, "fair_g1", 64'(g1), 64'd6);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);

        // Reset mid-operation
        drv_pt();
        set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd6);
        @(negedge clk);
        check_eq("rmid_rdy0", if0.req_ready, 1'b1);
        drv_pt();
        set_req(0, 1'b0, '0, '0, '0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rmid_alu", {alu_ctl, alu_a, alu_b}, '0);
        check_eq("rmid_rsp", {rsp_of(0), rsp_of(1)}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_pulse = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if0.rsp_valid) no_pulse = 1'b0;
        end
        check_eq("rmid_no_rsp0", no_pulse, 1'b1);
        drv_pt();
        set_req(0, 1'b1, ALU_AND, 32'h3, 32'h6);
        set_req(1, 1'b1, ALU_OR, 32'h3, 32'h6);
        @(negedge clk);
        check_eq("rmid_tie", {if0.req_ready, if1.req_ready}, 2'b10);
        drv_pt();
        set_req(0, 1'b0, '0, '0, '0);
        @(negedge clk);
        drv_pt();
        set_req(1, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);

        check_eq("sb0_empty_end", 64'(q0.size()), 64'd0);
        check_eq("sb1_empty_end", 64'(q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
